// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Scoreboard-based hazard and forwarding controller for an
//               in-order RV32 pipeline. It handles load-use interlock, branch
//               flush, global stall, and saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int RF_ADDR_W = 5,
  parameter int NUM_SRC   = 2,
  parameter int NUM_STG   = 3,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 16,
  parameter int SEL_W     = $clog2(NUM_STG)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ext_stall,
  input  logic                         id_valid,
  input  logic [NUM_SRC*RF_ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]           id_rs_used,
  input  logic [RF_ADDR_W-1:0]         id_rd,
  input  logic                         id_reg_write,
  input  logic                         id_mem_read,
  input  logic                         ex_redirect,
  output logic                         stall_if_id,
  output logic                         flush_if_id,
  output logic                         bubble_ex,
  output logic [NUM_SRC*SEL_W-1:0]     fwd_sel,
  output logic                         ex_valid,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             flush_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic                         r_valid     [NUM_STG];
  logic [RF_ADDR_W-1:0]         r_rd        [NUM_STG];
  logic                         r_reg_write [NUM_STG];
  logic                         r_mem_read  [NUM_STG];
  logic [NUM_SRC*RF_ADDR_W-1:0] r_ex_rs;
  logic [NUM_SRC-1:0]           r_ex_rs_used;
  logic [CNT_W-1:0]             r_stall_cnt;
  logic [CNT_W-1:0]             r_flush_cnt;
  logic                         w_load_use;

  // A load is not forwardable while it sits in the first LOAD_LAT positions.
  always_comb begin
    w_load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < LOAD_LAT; k++) begin
        if (id_valid && id_rs_used[i] &&
            (id_rs[i*RF_ADDR_W +: RF_ADDR_W] != '0) &&
            r_valid[k] && r_reg_write[k] && r_mem_read[k] &&
            (r_rd[k] == id_rs[i*RF_ADDR_W +: RF_ADDR_W])) begin
          w_load_use = 1'b1;
        end
      end
    end
  end

  assign stall_if_id = ext_stall | (w_load_use & ~ex_redirect);
  assign flush_if_id = ex_redirect & ~ext_stall;
  assign bubble_ex   = ~ext_stall & (w_load_use | ex_redirect);
  assign ex_valid    = r_valid[0];
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    logic [RF_ADDR_W-1:0] w_src;
    logic [SEL_W-1:0]     w_sel;

    assign w_src = r_ex_rs[i*RF_ADDR_W +: RF_ADDR_W];

    // Scan oldest to youngest so the youngest producer overrides.
    always_comb begin
      w_sel = '0;
      if (r_valid[0] && r_ex_rs_used[i] && (w_src != '0)) begin
        for (int k = NUM_STG - 1; k >= 1; k--) begin
          if (r_valid[k] && r_reg_write[k] && (r_rd[k] == w_src)) begin
            w_sel = SEL_W'(k);
          end
        end
      end
    end

    assign fwd_sel[i*SEL_W +: SEL_W] = w_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_STG; k++) begin
        r_valid[k]     <= 1'b0;
        r_rd[k]        <= '0;
        r_reg_write[k] <= 1'b0;
        r_mem_read[k]  <= 1'b0;
      end
      r_ex_rs      <= '0;
      r_ex_rs_used <= '0;
    end else if (!ext_stall) begin
      for (int k = 1; k < NUM_STG; k++) begin
        r_valid[k]     <= r_valid[k-1];
        r_rd[k]        <= r_rd[k-1];
        r_reg_write[k] <= r_reg_write[k-1];
        r_mem_read[k]  <= r_mem_read[k-1];
      end
      r_valid[0]     <= id_valid & ~bubble_ex;
      r_rd[0]        <= id_rd;
      r_reg_write[0] <= id_reg_write;
      r_mem_read[0]  <= id_mem_read;
      r_ex_rs        <= id_rs;
      r_ex_rs_used   <= id_rs_used;
    end
  end

  // Counters keep running through ext_stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_if_id && (r_stall_cnt != c_cnt_max)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush_if_id && (r_flush_cnt != c_cnt_max)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. It uses a vector
//               table, a randomized queue model, and a deep-pipe/saturation check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int STG = 3;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default-parameter instance
  logic        reset, ext_stall, id_valid, id_reg_write, id_mem_read, ex_redirect;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        stall_if_id, flush_if_id, bubble_ex, ex_valid;
  logic [3:0]  fwd_sel;
  logic [15:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_redirect(ex_redirect),
    .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .bubble_ex(bubble_ex),
    .fwd_sel(fwd_sel), .ex_valid(ex_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Deep-pipe instance: NUM_STG=4, LOAD_LAT=2
  logic        b_reset, b_ext_stall, b_id_valid, b_id_reg_write, b_id_mem_read, b_ex_redirect;
  logic [9:0]  b_id_rs;
  logic [1:0]  b_id_rs_used;
  logic [4:0]  b_id_rd;
  logic        b_stall_if_id, b_flush_if_id, b_bubble_ex, b_ex_valid;
  logic [3:0]  b_fwd_sel;
  logic [15:0] b_stall_cnt, b_flush_cnt;

  pipe_hazard_ctrl #(.NUM_STG(4), .LOAD_LAT(2)) dut_b (
    .clk(clk), .reset(b_reset), .ext_stall(b_ext_stall), .id_valid(b_id_valid),
    .id_rs(b_id_rs), .id_rs_used(b_id_rs_used), .id_rd(b_id_rd),
    .id_reg_write(b_id_reg_write), .id_mem_read(b_id_mem_read), .ex_redirect(b_ex_redirect),
    .stall_if_id(b_stall_if_id), .flush_if_id(b_flush_if_id), .bubble_ex(b_bubble_ex),
    .fwd_sel(b_fwd_sel), .ex_valid(b_ex_valid), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit       ext, idv;
    bit [4:0] rs0, rs1;
    bit [1:0] used;
    bit [4:0] rd;
    bit       wr, ld, redir;
    bit       e_stall, e_flush, e_bub;
    int       e_f0, e_f1;
    bit       e_exv;
    int       e_sc, e_fc;
  } vec_t;

  function automatic vec_t v(bit ext, bit idv, bit [4:0] rs0, bit [4:0] rs1, bit [1:0] used,
                             bit [4:0] rd, bit wr, bit ld, bit redir, bit es, bit ef, bit eb,
                             int f0, int f1, bit exv, int sc, int fc);
    vec_t r;
    r.ext = ext; r.idv = idv; r.rs0 = rs0; r.rs1 = rs1; r.used = used; r.rd = rd;
    r.wr = wr; r.ld = ld; r.redir = redir; r.e_stall = es; r.e_flush = ef; r.e_bub = eb;
    r.e_f0 = f0; r.e_f1 = f1; r.e_exv = exv; r.e_sc = sc; r.e_fc = fc;
    return r;
  endfunction

  vec_t tbl[30];

  // ---------------- queue reference model (index 0 = EX) ----------------
  typedef struct packed {
    bit            v;
    bit [4:0]      rd;
    bit            wr;
    bit            ld;
    bit [1:0][4:0] rs;
    bit [1:0]      used;
  } ent_t;

  ent_t pipe[$];
  int   m_sc, m_fc;

  task automatic model_reset();
    pipe.delete();
    repeat (STG) pipe.push_back('0);
    m_sc = 0;
    m_fc = 0;
  endtask

  task automatic model_check_and_step();
    bit   lu, e_stall, e_flush, e_bub;
    int   f;
    ent_t n;
    lu = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < LAT; k++)
        if (id_valid && id_rs_used[i] && id_rs[i*5 +: 5] != 0 && pipe[k].v && pipe[k].wr &&
            pipe[k].ld && pipe[k].rd == id_rs[i*5 +: 5]) lu = 1'b1;
    e_stall = ext_stall || (lu && !ex_redirect);
    e_flush = ex_redirect && !ext_stall;
    e_bub   = !ext_stall && (lu || ex_redirect);
    if (!reset) begin
      chk("rnd_stall", int'(stall_if_id), int'(e_stall));
      chk("rnd_flush", int'(flush_if_id), int'(e_flush));
      chk("rnd_bubble", int'(bubble_ex), int'(e_bub));
      chk("rnd_ex_valid", int'(ex_valid), int'(pipe[0].v));
      chk("rnd_stall_cnt", int'(stall_cnt), m_sc);
      chk("rnd_flush_cnt", int'(flush_cnt), m_fc);
      for (int i = 0; i < 2; i++) begin
        f = 0;
        if (pipe[0].v && pipe[0].used[i] && pipe[0].rs[i] != 0)
          for (int k = 1; k < STG; k++)
            if (f == 0 && pipe[k].v && pipe[k].wr && pipe[k].rd == pipe[0].rs[i]) f = k;
        chk(i == 0 ? "rnd_fwd0" : "rnd_fwd1", int'(fwd_sel[i*2 +: 2]), f);
      end
    end
    if (reset) begin
      model_reset();
    end else begin
      if (e_stall && m_sc != 65535) m_sc++;
      if (e_flush && m_fc != 65535) m_fc++;
      if (!ext_stall) begin
        n = '0;
        if (id_valid && !e_bub) begin
          n.v = 1'b1; n.rd = id_rd; n.wr = id_reg_write; n.ld = id_mem_read;
          n.rs = id_rs; n.used = id_rs_used;
        end
        void'(pipe.pop_back());
        pipe.push_front(n);
      end
    end
  endtask

  initial begin
    reset = 1'b1; ext_stall = 0; id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_reg_write = 0; id_mem_read = 0; ex_redirect = 0;
    b_reset = 1'b1; b_ext_stall = 0; b_id_valid = 0; b_id_rs = '0; b_id_rs_used = '0;
    b_id_rd = '0; b_id_reg_write = 0; b_id_mem_read = 0; b_ex_redirect = 0;

    //            ext idv rs0 rs1 use rd wr ld rdr | st fl bu f0 f1 exv sc fc
    tbl[0]  = v(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v(0, 1, 0, 0, 0, 5,  1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = v(0, 1, 5, 7, 3, 6,  1, 0, 0,  1, 0, 1, 0, 0, 1, 0, 0);
    tbl[3]  = v(0, 1, 5, 7, 3, 6,  1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    tbl[4]  = v(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 2, 0, 1, 1, 0);
    tbl[5]  = v(0, 1, 0, 0, 0, 5,  1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    tbl[6]  = v(0, 1, 5, 5, 3, 8,  1, 0, 0,  0, 0, 0, 0, 0, 1, 1, 0);
    tbl[7]  = v(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 1, 1, 1, 0);
    tbl[8]  = v(0, 1, 0, 0, 0, 5,  1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    tbl[9]  = v(0, 1, 1, 2, 3, 9,  1, 0, 0,  0, 0, 0, 0, 0, 1, 1, 0);
    tbl[10] = v(0, 1, 5, 5, 3, 8,  1, 0, 0,  0, 0, 0, 0, 0, 1, 1, 0);
    tbl[11] = v(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 2, 2, 1, 1, 0);
    tbl[12] = v(0, 1, 0, 0, 0, 5,  1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    tbl[13] = v(0, 1, 0, 0, 0, 5,  1, 0, 0,  0, 0, 0, 0, 0, 1, 1, 0);
    tbl[14] = v(0, 1, 5, 0, 1, 10, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1, 0);
    tbl[15] = v(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0, 1, 1, 0);
    tbl[16] = v(0, 1, 0, 0, 0, 0,  1, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    tbl[17] = v(0, 1, 0, 0, 1, 11, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1, 0);
    tbl[18] = v(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 0);
    tbl[19] = v(0, 1, 0, 0, 0, 5,  1, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    tbl[20] = v(0, 1, 5, 7, 3, 6,  1, 0, 1,  0, 1, 1, 0, 0, 1, 1, 0);
    tbl[21] = v(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1);
    tbl[22] = v(0, 1, 0, 0, 0, 5,  1, 1, 0,  0, 0, 0, 0, 0, 0, 1, 1);
    tbl[23] = v(1, 1, 5, 7, 3, 6,  1, 0, 0,  1, 0, 0, 0, 0, 1, 1, 1);
    tbl[24] = v(1, 1, 5, 7, 3, 6,  1, 0, 0,  1, 0, 0, 0, 0, 1, 2, 1);
    tbl[25] = v(1, 1, 5, 7, 3, 6,  1, 0, 0,  1, 0, 0, 0, 0, 1, 3, 1);
    tbl[26] = v(0, 1, 5, 7, 3, 6,  1, 0, 0,  1, 0, 1, 0, 0, 1, 4, 1);
    tbl[27] = v(1, 0, 0, 0, 0, 0,  0, 0, 1,  1, 0, 0, 0, 0, 0, 5, 1);
    tbl[28] = v(0, 0, 0, 0, 0, 0,  0, 0, 1,  0, 1, 1, 0, 0, 0, 6, 1);
    tbl[29] = v(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 6, 2);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    b_reset = 1'b0;

    for (int r = 0; r < 30; r++) begin
      ext_stall = tbl[r].ext; id_valid = tbl[r].idv; id_rs = {tbl[r].rs1, tbl[r].rs0};
      id_rs_used = tbl[r].used; id_rd = tbl[r].rd; id_reg_write = tbl[r].wr;
      id_mem_read = tbl[r].ld; ex_redirect = tbl[r].redir;
      #1;
      chk($sformatf("vec%0d_stall", r), int'(stall_if_id), int'(tbl[r].e_stall));
      chk($sformatf("vec%0d_flush", r), int'(flush_if_id), int'(tbl[r].e_flush));
      chk($sformatf("vec%0d_bubble", r), int'(bubble_ex), int'(tbl[r].e_bub));
      chk($sformatf("vec%0d_fwd0", r), int'(fwd_sel[1:0]), tbl[r].e_f0);
      chk($sformatf("vec%0d_fwd1", r), int'(fwd_sel[3:2]), tbl[r].e_f1);
      chk($sformatf("vec%0d_ex_valid", r), int'(ex_valid), int'(tbl[r].e_exv));
      chk($sformatf("vec%0d_stall_cnt", r), int'(stall_cnt), tbl[r].e_sc);
      chk($sformatf("vec%0d_flush_cnt", r), int'(flush_cnt), tbl[r].e_fc);
      @(negedge clk);
    end

    // Randomized run against the queue model, starting from a fresh reset
    reset = 1'b1; ext_stall = 0; id_valid = 0; ex_redirect = 0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 499) == 0);
      ext_stall    = ($urandom_range(0, 9) == 0);
      ex_redirect  = ($urandom_range(0, 7) == 0);
      id_valid     = ($urandom_range(0, 5) != 0);
      id_rs        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_rs_used   = 2'($urandom_range(0, 3));
      id_rd        = 5'($urandom_range(0, 3));
      id_reg_write = ($urandom_range(0, 3) != 0);
      id_mem_read  = ($urandom_range(0, 2) == 0);
      #1;
      model_check_and_step();
      @(negedge clk);
    end
    reset = 1'b0; ext_stall = 0; id_valid = 0; ex_redirect = 0;

    // Deep pipe: lw x5, independent, use x5 -> exactly one stall cycle
    b_id_valid = 1; b_id_rd = 5; b_id_reg_write = 1; b_id_mem_read = 1;
    b_id_rs = '0; b_id_rs_used = 2'b00;
    #1 chk("b_lw_stall", int'(b_stall_if_id), 0);
    @(negedge clk);
    b_id_rd = 9; b_id_mem_read = 0; b_id_rs = {5'd2, 5'd1}; b_id_rs_used = 2'b11;
    #1 chk("b_indep_stall", int'(b_stall_if_id), 0);
    @(negedge clk);
    b_id_rd = 6; b_id_rs = {5'd7, 5'd5};
    #1 chk("b_use_stall", int'(b_stall_if_id), 1);
    chk("b_use_bubble", int'(b_bubble_ex), 1);
    @(negedge clk);
    #1 chk("b_use_release", int'(b_stall_if_id), 0);
    @(negedge clk);
    // Use now in EX; freeze the pipe here and push the counter to saturation
    b_id_valid = 0; b_ext_stall = 1;
    #1 chk("b_fwd0", int'(b_fwd_sel[1:0]), 3);
    chk("b_fwd1", int'(b_fwd_sel[3:2]), 0);
    chk("b_stall_cnt1", int'(b_stall_cnt), 1);
    repeat (65540) @(negedge clk);
    #1 chk("b_stall_cnt_sat", int'(b_stall_cnt), 65535);
    chk("b_frozen_fwd0", int'(b_fwd_sel[1:0]), 3);
    chk("b_frozen_ex_valid", int'(b_ex_valid), 1);
    @(negedge clk);
    #1 chk("b_stall_cnt_hold", int'(b_stall_cnt), 65535);
    b_reset = 1'b1;
    @(negedge clk);
    b_reset = 1'b0; b_ext_stall = 0;
    #1 chk("b_reset_stall_cnt", int'(b_stall_cnt), 0);
    chk("b_reset_ex_valid", int'(b_ex_valid), 0);
    chk("b_reset_fwd", int'(b_fwd_sel), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
